// File: rtl/spi_flash_emu.sv
// ============================================================================
//  Module      : spi_flash_emu
//  Description : SPI-mode-3 serial NOR flash responder. Serves the READ (0x03)
//                command from a BRAM read port. All SPI inputs are oversampled
//                in the i_clk domain; there is no SPI-clocked logic.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_flash_emu #(
    parameter int ADDR_W   = 10,
    parameter int SYNC_STG = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_spi_cs_n,
    input  logic              i_spi_clk,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    output logic              o_read_bram_stb,
    output logic [ADDR_W-1:0] o_read_bram_addr,
    input  logic [7:0]        i_read_bram_data,
    output logic              o_cmd_stb,
    output logic [7:0]        o_cmd,
    output logic              o_addr_stb,
    output logic [23:0]       o_addr,
    output logic              o_busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_IGNORE = 3'd4;

    localparam logic [7:0]        CMD_READ = 8'h03;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STG-1:0] cs_sync_q;
    logic [SYNC_STG-1:0] sck_sync_q;
    logic [SYNC_STG-1:0] mosi_sync_q;
    logic                cs_prev_q;
    logic                sck_prev_q;

    // CS chain resets to "asserted" so a transaction already running when
    // reset releases never shows a falling edge and is ignored until CS high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cs_sync_q   <= '0;
            sck_sync_q  <= '1;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b0;
            sck_prev_q  <= 1'b1;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STG-2:0],   i_spi_cs_n};
            sck_sync_q  <= {sck_sync_q[SYNC_STG-2:0],  i_spi_clk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STG-2:0], i_spi_mosi};
            cs_prev_q   <= cs_sync_q[SYNC_STG-1];
            sck_prev_q  <= sck_sync_q[SYNC_STG-1];
        end
    end

    logic w_cs;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_sck;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_mosi;

    assign w_cs       = cs_sync_q[SYNC_STG-1];
    assign w_cs_fall  = cs_prev_q & ~w_cs;
    assign w_cs_rise  = ~cs_prev_q & w_cs;
    assign w_sck      = sck_sync_q[SYNC_STG-1];
    // SCK edges only count while CS is (synchronously) asserted
    assign w_sck_rise = ~sck_prev_q & w_sck & ~w_cs;
    assign w_sck_fall = sck_prev_q & ~w_sck & ~w_cs;
    assign w_mosi     = mosi_sync_q[SYNC_STG-1];

    // ------------------------------------------------------------------
    // State machine and datapath registers
    // ------------------------------------------------------------------
    logic [2:0]        state_q,     state_d;
    logic [4:0]        bit_cnt_q,   bit_cnt_d;
    logic [22:0]       rx_q,        rx_d;
    logic [7:0]        tx_q,        tx_d;
    logic              miso_q,      miso_d;
    logic [7:0]        cmd_q,       cmd_d;
    logic [23:0]       addr_q,      addr_d;
    logic              cmd_stb_q,   cmd_stb_d;
    logic              addr_stb_q,  addr_stb_d;
    logic              bram_stb_q,  bram_stb_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic              pend_q,      pend_d;

    // Received byte / address including the bit arriving this cycle
    logic [7:0]  w_rx_byte;
    logic [23:0] w_rx_addr;

    assign w_rx_byte = {rx_q[6:0], w_mosi};
    assign w_rx_addr = {rx_q, w_mosi};

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; CS deassert returns to IDLE from any state
    always_comb begin
        state_d = state_q;
        if (w_cs_rise) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_cs_fall) state_d = ST_CMD;
                end
                ST_CMD: begin
                    if (w_sck_rise && bit_cnt_q == 5'd7)
                        state_d = (w_rx_byte == CMD_READ) ? ST_ADDR : ST_IGNORE;
                end
                ST_ADDR: begin
                    if (w_sck_rise && bit_cnt_q == 5'd23) state_d = ST_DATA;
                end
                ST_DATA:   state_d = ST_DATA;
                ST_IGNORE: state_d = ST_IGNORE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Output / datapath next values: shifting, strobes, BRAM prefetch
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        cmd_stb_d   = 1'b0;
        addr_stb_d  = 1'b0;
        bram_stb_d  = 1'b0;
        bram_addr_d = bram_addr_q;
        pend_d      = 1'b0;
        if (w_cs_rise || state_q == ST_IDLE) begin
            // Partial bytes and in-flight BRAM data are discarded here
            bit_cnt_d = 5'd0;
            rx_d      = '0;
            tx_d      = 8'hFF;
            miso_d    = 1'b1;
        end else begin
            case (state_q)
                ST_CMD: begin
                    miso_d = 1'b1;
                    if (w_sck_rise) begin
                        rx_d = w_rx_addr[22:0];
                        if (bit_cnt_q == 5'd7) begin
                            cmd_d     = w_rx_byte;
                            cmd_stb_d = 1'b1;
                            bit_cnt_d = 5'd0;
                            rx_d      = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                ST_ADDR: begin
                    miso_d = 1'b1;
                    if (w_sck_rise) begin
                        rx_d = w_rx_addr[22:0];
                        if (bit_cnt_q == 5'd23) begin
                            addr_d      = w_rx_addr;
                            addr_stb_d  = 1'b1;
                            bram_stb_d  = 1'b1;
                            bram_addr_d = w_rx_addr[ADDR_W-1:0];
                            bit_cnt_d   = 5'd0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                ST_DATA: begin
                    // BRAM data is valid the cycle after the strobe is seen
                    pend_d = bram_stb_q;
                    if (pend_q) begin
                        tx_d = i_read_bram_data;
                    end
                    if (w_sck_fall) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b1};
                    end
                    if (w_sck_rise) begin
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d   = 5'd0;
                            bram_addr_d = bram_addr_q + ADDR_ONE;
                            bram_stb_d  = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                default: begin
                    miso_d = 1'b1;
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bit_cnt_q   <= 5'd0;
            rx_q        <= '0;
            tx_q        <= 8'hFF;
            miso_q      <= 1'b1;
            cmd_q       <= 8'h00;
            addr_q      <= 24'h000000;
            cmd_stb_q   <= 1'b0;
            addr_stb_q  <= 1'b0;
            bram_stb_q  <= 1'b0;
            bram_addr_q <= '0;
            pend_q      <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            cmd_stb_q   <= cmd_stb_d;
            addr_stb_q  <= addr_stb_d;
            bram_stb_q  <= bram_stb_d;
            bram_addr_q <= bram_addr_d;
            pend_q      <= pend_d;
        end
    end

    assign o_spi_miso       = miso_q;
    assign o_read_bram_stb  = bram_stb_q;
    assign o_read_bram_addr = bram_addr_q;
    assign o_cmd_stb        = cmd_stb_q;
    assign o_cmd            = cmd_q;
    assign o_addr_stb       = addr_stb_q;
    assign o_addr           = addr_q;
    assign o_busy           = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_emu.sv
// ============================================================================
//  Module      : tb_spi_flash_emu
//  Description : Self-checking bench for spi_flash_emu. A mode-3 SPI master
//                task drives transactions; expected MISO bytes and BRAM read
//                addresses come from a flat memory array and modulo arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_flash_emu;

    localparam int ADDR_W   = 10;
    localparam int SYNC_STG = 2;
    localparam int MEM_SZ   = 1 << ADDR_W;
    localparam int HP       = 8;   // SCK half period in clk cycles

    logic              clk = 1'b0;
    logic              rst;
    logic              cs_n;
    logic              sck;
    logic              mosi;
    logic              miso;
    logic              bram_stb;
    logic [ADDR_W-1:0] bram_addr;
    logic [7:0]        bram_data;
    logic              cmd_stb;
    logic [7:0]        cmd;
    logic              addr_stb;
    logic [23:0]       addr;
    logic              busy;

    always #5 clk = ~clk;

    spi_flash_emu #(.ADDR_W(ADDR_W), .SYNC_STG(SYNC_STG)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_spi_cs_n       (cs_n),
        .i_spi_clk        (sck),
        .i_spi_mosi       (mosi),
        .o_spi_miso       (miso),
        .o_read_bram_stb  (bram_stb),
        .o_read_bram_addr (bram_addr),
        .i_read_bram_data (bram_data),
        .o_cmd_stb        (cmd_stb),
        .o_cmd            (cmd),
        .o_addr_stb       (addr_stb),
        .o_addr           (addr),
        .o_busy           (busy)
    );

    // Flash contents and BRAM model: data valid one cycle after the request
    logic [7:0] mem [MEM_SZ];
    always @(posedge clk) bram_data <= mem[bram_addr];

    // Observed activity, cleared by the stimulus process on negedges
    int unsigned rd_q[$];
    int          cmd_stb_cnt;
    int          addr_stb_cnt;
    always @(posedge clk) begin
        if (bram_stb) rd_q.push_back(32'(bram_addr));
        if (cmd_stb)  cmd_stb_cnt  = cmd_stb_cnt + 1;
        if (addr_stb) addr_stb_cnt = addr_stb_cnt + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] mosi_buf [64];
    logic [7:0] miso_buf [64];
    logic       busy_seen;

    task automatic clear_obs();
        rd_q.delete();
        cmd_stb_cnt  = 0;
        addr_stb_cnt = 0;
    endtask

    // Mode-3 master: drive MOSI on SCK fall, sample MISO just before SCK rise.
    // rst_bit >= 0 pulses reset for one cycle during that bit's low phase.
    task automatic spi_xfer(input int nbits, input int rst_bit);
        @(negedge clk);
        clear_obs();
        cs_n = 1'b0;
        repeat (HP) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            sck  = 1'b0;
            mosi = mosi_buf[b / 8][7 - (b % 8)];
            if (b == rst_bit) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                rd_q.delete();
                repeat (HP - 1) @(negedge clk);
            end else begin
                repeat (HP) @(negedge clk);
            end
            if (b == 0) busy_seen = busy;
            miso_buf[b / 8][7 - (b % 8)] = miso;
            sck = 1'b1;
            repeat (HP) @(negedge clk);
        end
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (HP) @(negedge clk);
    endtask

    task automatic set_read(input logic [7:0] c, input int unsigned a);
        logic [23:0] a24;
        a24 = 24'(a);
        mosi_buf[0] = c;
        mosi_buf[1] = a24[23:16];
        mosi_buf[2] = a24[15:8];
        mosi_buf[3] = a24[7:0];
        for (int i = 4; i < 64; i++) mosi_buf[i] = 8'($urandom);
    endtask

    // Checks a complete READ of n bytes starting at flash address a
    task automatic check_read(input string tag, input int unsigned a, input int n);
        for (int i = 0; i < 4; i++)
            check_value($sformatf("%s miso_hdr%0d", tag, i), 32'(miso_buf[i]), 32'hFF);
        for (int k = 0; k < n; k++)
            check_value($sformatf("%s byte%0d", tag, k), 32'(miso_buf[4 + k]),
                        32'(mem[(a + k) % MEM_SZ]));
        check_value($sformatf("%s nreads", tag), 32'(rd_q.size()), 32'(n + 1));
        for (int k = 0; k < n + 1 && k < rd_q.size(); k++)
            check_value($sformatf("%s rdaddr%0d", tag, k), rd_q[k], (a + k) % MEM_SZ);
        check_value($sformatf("%s cmd_stb", tag), 32'(cmd_stb_cnt), 32'd1);
        check_value($sformatf("%s addr_stb", tag), 32'(addr_stb_cnt), 32'd1);
        check_value($sformatf("%s cmd", tag), 32'(cmd), 32'h03);
        check_value($sformatf("%s addr", tag), 32'(addr), a & 32'hFFFFFF);
        check_value($sformatf("%s busy_in", tag), 32'(busy_seen), 32'd1);
        check_value($sformatf("%s busy_out", tag), 32'(busy), 32'd0);
        check_value($sformatf("%s miso_idle", tag), 32'(miso), 32'd1);
    endtask

    initial begin
        logic [7:0]  rc;
        int unsigned ra;
        int          rn;
        logic [7:0]  partial;
        logic [7:0]  exp_b;

        rst  = 1'b1;
        cs_n = 1'b1;
        sck  = 1'b1;
        mosi = 1'b0;
        cmd_stb_cnt  = 0;
        addr_stb_cnt = 0;
        for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'(i) ^ 8'hA5;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check_value("rst miso", 32'(miso), 32'd1);
        check_value("rst busy", 32'(busy), 32'd0);
        check_value("rst cmd", 32'(cmd), 32'd0);
        check_value("rst addr", 32'(addr), 32'd0);
        check_value("rst bram_stb", 32'(bram_stb), 32'd0);
        check_value("rst bram_addr", 32'(bram_addr), 32'd0);
        check_value("rst cmd_stb", 32'(cmd_stb), 32'd0);
        check_value("rst addr_stb", 32'(addr_stb), 32'd0);
        repeat (10) @(negedge clk);

        // Basic read: 0x10, 4 bytes -> B5 B4 B7 B6
        set_read(8'h03, 32'h10);
        spi_xfer(64, -1);
        check_read("basic", 32'h10, 4);
        check_value("basic lit0", 32'(miso_buf[4]), 32'hB5);
        check_value("basic lit3", 32'(miso_buf[7]), 32'hB6);

        // Address wrap at the top of the BRAM
        set_read(8'h03, 32'h3FE);
        spi_xfer(56, -1);
        check_read("wrap", 32'h3FE, 3);

        // Unsupported command: ignored, MISO stays high, no reads
        set_read(8'h9F, 32'h123456);
        spi_xfer(40, -1);
        check_value("9f cmd", 32'(cmd), 32'h9F);
        check_value("9f cmd_stb", 32'(cmd_stb_cnt), 32'd1);
        check_value("9f addr_stb", 32'(addr_stb_cnt), 32'd0);
        check_value("9f nreads", 32'(rd_q.size()), 32'd0);
        check_value("9f addr_hold", 32'(addr), 32'h3FE);
        for (int i = 0; i < 5; i++)
            check_value($sformatf("9f miso%0d", i), 32'(miso_buf[i]), 32'hFF);

        // Abort after 3 data bits, then a clean read at 0x020
        set_read(8'h03, 32'h100);
        spi_xfer(35, -1);
        partial = miso_buf[4] >> 5;
        exp_b   = mem[32'h100] >> 5;
        check_value("abort partial", 32'(partial), 32'(exp_b));
        check_value("abort busy", 32'(busy), 32'd0);
        check_value("abort miso", 32'(miso), 32'd1);
        set_read(8'h03, 32'h20);
        spi_xfer(40, -1);
        check_read("restart", 32'h20, 1);

        // Reset pulse in the middle of the data phase
        set_read(8'h03, 32'h40);
        spi_xfer(64, 43);
        check_value("rstmid byte4", 32'(miso_buf[4]), 32'(mem[32'h40]));
        check_value("rstmid miso6", 32'(miso_buf[6]), 32'hFF);
        check_value("rstmid miso7", 32'(miso_buf[7]), 32'hFF);
        check_value("rstmid nreads", 32'(rd_q.size()), 32'd0);
        check_value("rstmid busy", 32'(busy), 32'd0);
        check_value("rstmid miso", 32'(miso), 32'd1);
        set_read(8'h03, 32'h2C5);
        spi_xfer(48, -1);
        check_read("after_rst", 32'h2C5, 2);

        // Randomized transactions against the memory model
        for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'($urandom);
        for (int t = 0; t < 20; t++) begin
            ra = $urandom & 32'hFFFFFF;
            rn = $urandom_range(1, 5);
            if ($urandom_range(0, 3) == 0) begin
                rc = 8'($urandom);
                if (rc == 8'h03) rc = 8'h0B;
                set_read(rc, ra);
                spi_xfer(32 + 8 * rn, -1);
                check_value($sformatf("rnd%0d ign cmd", t), 32'(cmd), 32'(rc));
                check_value($sformatf("rnd%0d ign reads", t), 32'(rd_q.size()), 32'd0);
                check_value($sformatf("rnd%0d ign addr_stb", t), 32'(addr_stb_cnt), 32'd0);
                for (int k = 0; k < 4 + rn; k++)
                    check_value($sformatf("rnd%0d ign miso%0d", t, k), 32'(miso_buf[k]), 32'hFF);
            end else begin
                set_read(8'h03, ra);
                spi_xfer(32 + 8 * rn, -1);
                check_read($sformatf("rnd%0d", t), ra, rn);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
